// File: rtl/ad9361_tdd_sequencer_pkg.sv
// Shared types and defaults for the AD9361 TDD sequencer.
package ad9361_tdd_sequencer_pkg;

  localparam int unsigned CntWidthDefault = 24;
  localparam int unsigned FrmWidthDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun
  } tdd_state_e;

  typedef enum logic [1:0] {
    DesOff,
    DesRx,
    DesTx
  } tdd_desired_e;

endpackage

// File: rtl/ad9361_tdd_window.sv
// Half-open window compare: active while on <= cnt < off, empty when on >= off.
module ad9361_tdd_window
  import ad9361_tdd_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CntWidthDefault
) (
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [CNT_WIDTH-1:0] on,
  input  logic [CNT_WIDTH-1:0] off,
  output logic                 active
);

  assign active = (cnt >= on) && (cnt < off);

endmodule

// File: rtl/ad9361_tdd_sequencer.sv
// TDD frame sequencer driving the AD9361 ENSM in level mode: frame counter,
// RX/TX windows and gap-protected up_enable/up_txnrx generation.
module ad9361_tdd_sequencer
  import ad9361_tdd_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CntWidthDefault,
  parameter int unsigned FRM_WIDTH = FrmWidthDefault
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  input  logic                 tdd_enable,
  input  logic                 sync_ext_en,
  input  logic [CNT_WIDTH-1:0] frame_length,
  input  logic [FRM_WIDTH-1:0] frame_count,
  input  logic [CNT_WIDTH-1:0] rx_on,
  input  logic [CNT_WIDTH-1:0] rx_off,
  input  logic [CNT_WIDTH-1:0] tx_on,
  input  logic [CNT_WIDTH-1:0] tx_off,
  input  logic                 tdd_sync_i,
  output logic                 tdd_sync_o,
  output logic                 tdd_sync_t,
  output logic                 up_enable,
  output logic                 up_txnrx,
  output logic                 busy,
  output logic                 done
);

  tdd_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [FRM_WIDTH-1:0] frm_q, frm_d, frm_inc;
  logic                 slave_q, slave_d;
  logic [CNT_WIDTH-1:0] frame_length_q, frame_length_d;
  logic [FRM_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0] rx_on_q, rx_on_d, rx_off_q, rx_off_d;
  logic [CNT_WIDTH-1:0] tx_on_q, tx_on_d, tx_off_q, tx_off_d;
  logic                 sync_prev_q;
  logic                 sync_o_q, sync_o_d;
  logic                 done_q, done_d;
  logic                 up_enable_q, up_enable_d;
  logic                 up_txnrx_q, up_txnrx_d;
  logic                 sync_edge, rx_active, tx_active, want_tx;
  tdd_desired_e         desired;

  ad9361_tdd_window #(.CNT_WIDTH(CNT_WIDTH)) u_rx_window (
    .cnt   (cnt_q),
    .on    (rx_on_q),
    .off   (rx_off_q),
    .active(rx_active)
  );

  ad9361_tdd_window #(.CNT_WIDTH(CNT_WIDTH)) u_tx_window (
    .cnt   (cnt_q),
    .on    (tx_on_q),
    .off   (tx_off_q),
    .active(tx_active)
  );

  assign sync_edge = tdd_sync_i & ~sync_prev_q;
  assign frm_inc   = frm_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frm_d          = frm_q;
    slave_d        = slave_q;
    frame_length_d = frame_length_q;
    frame_count_d  = frame_count_q;
    rx_on_d        = rx_on_q;
    rx_off_d       = rx_off_q;
    tx_on_d        = tx_on_q;
    tx_off_d       = tx_off_q;
    sync_o_d       = 1'b0;
    done_d         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tdd_enable) begin
          slave_d        = sync_ext_en;
          frame_length_d = frame_length;
          frame_count_d  = frame_count;
          rx_on_d        = rx_on;
          rx_off_d       = rx_off;
          tx_on_d        = tx_on;
          tx_off_d       = tx_off;
          cnt_d          = '0;
          frm_d          = '0;
          state_d        = sync_ext_en ? StArmed : StRun;
          sync_o_d       = ~sync_ext_en;
        end
      end
      StArmed: begin
        if (!tdd_enable) begin
          state_d = StIdle;
        end else if (sync_edge) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (!tdd_enable) begin
          state_d = StIdle;
        end else if (cnt_q == frame_length_q || (slave_q && sync_edge)) begin
          cnt_d = '0;
          frm_d = frm_inc;
          // frame_count of 0 means run until tdd_enable drops
          if (frame_count_q != '0 && frm_inc == frame_count_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            sync_o_d = ~slave_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (state_q != StRun) begin
      desired = DesOff;
    end else if (tx_active) begin
      desired = DesTx;
    end else if (rx_active) begin
      desired = DesRx;
    end else begin
      desired = DesOff;
    end
  end

  // Direction only moves while the ENSM enable is low on both sides of the edge.
  always_comb begin
    want_tx     = (desired == DesTx);
    up_enable_d = up_enable_q;
    up_txnrx_d  = up_txnrx_q;
    if (state_d != StRun || desired == DesOff) begin
      up_enable_d = 1'b0;
    end else if (want_tx != up_txnrx_q) begin
      up_enable_d = 1'b0;
      if (!up_enable_q) begin
        up_txnrx_d = want_tx;
      end
    end else begin
      up_enable_d = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      frm_q          <= '0;
      slave_q        <= 1'b0;
      frame_length_q <= '0;
      frame_count_q  <= '0;
      rx_on_q        <= '0;
      rx_off_q       <= '0;
      tx_on_q        <= '0;
      tx_off_q       <= '0;
      sync_prev_q    <= 1'b0;
      sync_o_q       <= 1'b0;
      done_q         <= 1'b0;
      up_enable_q    <= 1'b0;
      up_txnrx_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frm_q          <= frm_d;
      slave_q        <= slave_d;
      frame_length_q <= frame_length_d;
      frame_count_q  <= frame_count_d;
      rx_on_q        <= rx_on_d;
      rx_off_q       <= rx_off_d;
      tx_on_q        <= tx_on_d;
      tx_off_q       <= tx_off_d;
      sync_prev_q    <= tdd_sync_i;
      sync_o_q       <= sync_o_d;
      done_q         <= done_d;
      up_enable_q    <= up_enable_d;
      up_txnrx_q     <= up_txnrx_d;
    end
  end

  assign tdd_sync_o = sync_o_q;
  assign tdd_sync_t = sync_ext_en;
  assign up_enable  = up_enable_q;
  assign up_txnrx   = up_txnrx_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule
